// File: rtl/tick_generator_if.sv
// rtl/tick_generator_if.sv - control/status bundle between tick_generator and its host
interface tick_generator_if #(
   parameter int NUM_CH = 5,
   parameter int CNT_W  = 32,
   parameter int CH_W   = 3
);
   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [CNT_W-1:0]  wr_period;
   logic [NUM_CH-1:0] ch_en;
   logic              sync;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] level;
   logic              tick_any;

   modport master (
      output wr_en, wr_ch, wr_period, ch_en, sync,
      input  tick, level, tick_any
   );

   modport slave (
      input  wr_en, wr_ch, wr_period, ch_en, sync,
      output tick, level, tick_any
   );
endinterface

// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - multi-channel programmable tick and 50% level source
module tick_generator #(
   parameter int                NUM_CH         = 5,
   parameter int                CNT_W          = 32,
   parameter int                CH_W           = 3,
   parameter logic [CNT_W-1:0]  DEFAULT_PERIOD = CNT_W'(25000000)
) (
   input  logic            clk,
   input  logic            rst,
   tick_generator_if.slave bus
);

   logic [CNT_W-1:0]  period_q [NUM_CH];
   logic [CNT_W-1:0]  period_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [CNT_W-1:0]  cnt_d    [NUM_CH];
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] level_q, level_d;
   logic              tick_any_q, tick_any_d;

   // Period registers: a write to an out-of-range channel matches no index and is dropped
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         period_d[i] = period_q[i];
         if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
            period_d[i] = bus.wr_period;
         end
      end
   end

   // Counters compare against the current period; >= keeps cnt bounded when P shrinks below cnt
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]   = cnt_q[i];
         tick_d[i]  = 1'b0;
         level_d[i] = level_q[i];
         if (bus.sync) begin
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
         end else if (!bus.ch_en[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= period_q[i]) begin
            cnt_d[i]   = '0;
            tick_d[i]  = 1'b1;
            level_d[i] = ~level_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      tick_any_d = |tick_d;
   end

   // State registers with asynchronous clear back to the default period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            period_q[i] <= DEFAULT_PERIOD;
            cnt_q[i]    <= '0;
         end
         tick_q     <= '0;
         level_q    <= '0;
         tick_any_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            period_q[i] <= period_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
         tick_q     <= tick_d;
         level_q    <= level_d;
         tick_any_q <= tick_any_d;
      end
   end

   assign bus.tick     = tick_q;
   assign bus.level    = level_q;
   assign bus.tick_any = tick_any_q;

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - directed self-checking bench for tick_generator
module tb_tick_generator;
   localparam int NUM_CH = 5;
   localparam int CNT_W  = 32;
   localparam int CH_W   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_err  = 0;
   int   edge_n = 0;
   int   per [NUM_CH];
   logic [NUM_CH-1:0] exp_t;

   tick_generator_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

   tick_generator #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEFAULT_PERIOD(32'd4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.wr_en     = 1'b0;
      bus.wr_ch     = '0;
      bus.wr_period = '0;
      bus.sync      = 1'b0;
      bus.ch_en     = '1;
      @(posedge clk);
      #1;
      check("rst_tick", 32'(bus.tick), 32'h0);
      check("rst_level", 32'(bus.level), 32'h0);
      check("rst_any", 32'(bus.tick_any), 32'h0);
      rst    = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      // Default period 4: ticks after edges 5, 10, 15 on every channel
      do_reset();
      for (int n = 1; n <= 15; n++) begin
         step();
         check("t1_tick", 32'(bus.tick), (n % 5 == 0) ? 32'h1f : 32'h0);
         check("t1_any", 32'(bus.tick_any), (n % 5 == 0) ? 32'h1 : 32'h0);
         check("t1_level", 32'(bus.level), ((n / 5) % 2 == 1) ? 32'h1f : 32'h0);
      end

      // P lowered to 2 below cnt on ch1: ticks after edges 4, 7, 10
      do_reset();
      step();
      step();
      bus.wr_en = 1'b1; bus.wr_ch = 3'd1; bus.wr_period = 32'd2;
      step();
      bus.wr_en = 1'b0;
      for (int n = 4; n <= 10; n++) begin
         step();
         check("t2_tick1", 32'(bus.tick[1]), (n == 4 || n == 7 || n == 10) ? 32'h1 : 32'h0);
         check("t2_tick0", 32'(bus.tick[0]), (n % 5 == 0) ? 32'h1 : 32'h0);
      end

      // P=0 on ch2: tick continuously high, level toggles every cycle
      do_reset();
      bus.wr_en = 1'b1; bus.wr_ch = 3'd2; bus.wr_period = 32'd0;
      step();
      bus.wr_en = 1'b0;
      check("t3_tick2_e1", 32'(bus.tick[2]), 32'h0);
      for (int n = 2; n <= 8; n++) begin
         step();
         check("t3_tick2", 32'(bus.tick[2]), 32'h1);
         check("t3_level2", 32'(bus.level[2]), (n % 2 == 0) ? 32'h1 : 32'h0);
      end

      // Out-of-range channel write is ignored
      do_reset();
      bus.wr_en = 1'b1; bus.wr_ch = 3'd7; bus.wr_period = 32'd1;
      step();
      bus.wr_en = 1'b0;
      for (int n = 2; n <= 10; n++) begin
         step();
         check("t4_tick", 32'(bus.tick), (n % 5 == 0) ? 32'h1f : 32'h0);
      end

      // Periods 3/5/7 on ch0..2, sync at edge 20 realigns everything
      do_reset();
      per = '{3, 5, 7, 4, 4};
      for (int c = 0; c < 3; c++) begin
         bus.wr_en = 1'b1; bus.wr_ch = 3'(c); bus.wr_period = 32'(per[c]);
         step();
      end
      bus.wr_en = 1'b0;
      while (edge_n < 19) step();
      bus.sync = 1'b1;
      step();
      bus.sync = 1'b0;
      check("t5_sync_level", 32'(bus.level), 32'h0);
      check("t5_sync_tick", 32'(bus.tick), 32'h0);
      for (int n = 21; n <= 30; n++) begin
         step();
         for (int c = 0; c < NUM_CH; c++) exp_t[c] = ((n - 20) % (per[c] + 1) == 0);
         check("t5_tick", 32'(bus.tick), 32'(exp_t));
         check("t5_any", 32'(bus.tick_any), 32'(|exp_t));
      end

      // ch0 disabled for edges 8..17, re-enabled at edge 18 -> first tick after edge 22
      do_reset();
      for (int n = 1; n <= 25; n++) begin
         step();
         check("t6_tick0", 32'(bus.tick[0]), (n == 5 || n == 22) ? 32'h1 : 32'h0);
         check("t6_level0", 32'(bus.level[0]), (n >= 5 && n < 22) ? 32'h1 : 32'h0);
         check("t6_tick1", 32'(bus.tick[1]), (n % 5 == 0) ? 32'h1 : 32'h0);
         if (n == 7)  bus.ch_en[0] = 1'b0;
         if (n == 17) bus.ch_en[0] = 1'b1;
      end
      check("t6_pre_tick", 32'(bus.tick), 32'h1e);
      check("t6_pre_level", 32'(bus.level), 32'h1e);
      rst = 1'b1;
      #2;
      check("t6_async_tick", 32'(bus.tick), 32'h0);
      check("t6_async_level", 32'(bus.level), 32'h0);
      check("t6_async_any", 32'(bus.tick_any), 32'h0);
      @(negedge clk);
      rst    = 1'b0;
      edge_n = 0;
      for (int n = 1; n <= 5; n++) begin
         step();
         check("t6_default_tick", 32'(bus.tick), (n == 5) ? 32'h1f : 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
